phy_tx_serial: RTL and testbench

// Transmit end of the PHY serial link: takes four 8-bit lanes (with per-lane valid) and

---
 rtl/phy_tx_serial.sv | 125 ++++++++++++
 tb/tb_phy_tx_serial.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_serial.sv
// ---------------------------------------------------------------------------
// phy_tx_serial : four-lane byte striper onto one MSB-first serial line
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module phy_tx_serial #(
  parameter logic [7:0] BC_SYMBOL   = 8'hBC,
  parameter int         SYNC_FRAMES = 1
) (
  input  logic       clk_32f,
  input  logic       rst,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic [7:0] data_in_3,
  input  logic       valid_in_0,
  input  logic       valid_in_1,
  input  logic       valid_in_2,
  input  logic       valid_in_3,
  output logic       serial_out,
  output logic       load_out,
  output logic       active_out,
  output logic       idle_out
);

  localparam int         SYNC_W    = $clog2(SYNC_FRAMES + 1);
  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        lane_cnt_q, lane_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0][7:0]   hold_q, hold_d;
  logic [2:0]        hold_v_q, hold_v_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              active_q, active_d;
  logic              idle_q, idle_d;

  logic              byte_end;
  logic              fb;
  logic              sync_done;
  logic              load;
  logic [7:0]        next_byte;

  // State register (all flops)
  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      bit_cnt_q  <= 3'd7;
      lane_cnt_q <= 2'd3;
      sh_q       <= 8'h00;
      hold_q     <= {3{BC_SYMBOL}};
      hold_v_q   <= 3'b000;
      sync_cnt_q <= '0;
      active_q   <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      sh_q       <= sh_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      sync_cnt_q <= sync_cnt_d;
      active_q   <= active_d;
      idle_q     <= idle_d;
    end
  end

  // Next-state logic. The first frame boundary after reset only starts the
  // preamble, so the switch happens once SYNC_FRAMES further boundaries passed.
  always_comb begin
    byte_end  = (bit_cnt_q == 3'd7);
    fb        = byte_end && (lane_cnt_q == 2'd3);
    sync_done = (sync_cnt_q == SYNC_W'(SYNC_FRAMES));
    state_d   = state_q;
    if ((state_q == ST_SYNC) && fb && sync_done) begin
      state_d = ST_ACTIVE;
    end
  end

  // Output and datapath logic
  always_comb begin
    load       = fb && ((state_q == ST_ACTIVE) || sync_done);
    bit_cnt_d  = bit_cnt_q + 3'd1;
    lane_cnt_d = byte_end ? lane_cnt_q + 2'd1 : lane_cnt_q;
    sync_cnt_d = sync_cnt_q;
    if ((state_q == ST_SYNC) && fb && !sync_done) begin
      sync_cnt_d = sync_cnt_q + SYNC_W'(1);
    end

    next_byte = BC_SYMBOL;
    if (load) begin
      next_byte = valid_in_0 ? data_in_0 : BC_SYMBOL;
    end else if (state_q == ST_ACTIVE) begin
      case (lane_cnt_q)
        2'd0:    next_byte = hold_v_q[0] ? hold_q[0] : BC_SYMBOL;
        2'd1:    next_byte = hold_v_q[1] ? hold_q[1] : BC_SYMBOL;
        2'd2:    next_byte = hold_v_q[2] ? hold_q[2] : BC_SYMBOL;
        default: next_byte = BC_SYMBOL;
      endcase
    end
    sh_d = byte_end ? next_byte : {sh_q[6:0], 1'b0};

    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    idle_d   = idle_q;
    if (load) begin
      hold_d   = {data_in_3, data_in_2, data_in_1};
      hold_v_d = {valid_in_3, valid_in_2, valid_in_1};
      idle_d   = ~(valid_in_0 | valid_in_1 | valid_in_2 | valid_in_3);
    end
    active_d = (state_d == ST_ACTIVE);
  end

  assign serial_out = sh_q[7];
  assign load_out   = load;
  assign active_out = active_q;
  assign idle_out   = idle_q;

endmodule

`default_nettype wire

// File: tb/tb_phy_tx_serial.sv
// ---------------------------------------------------------------------------
// tb_phy_tx_serial : scoreboard bench deserialising the line frame by frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_phy_tx_serial;

  localparam logic [7:0] BC = 8'hBC;

  typedef struct {
    logic [31:0] bits;
    logic        idle;
  } exp_t;

  logic       clk_32f = 1'b0;
  logic       rst;
  logic [7:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic       valid_in_0, valid_in_1, valid_in_2, valid_in_3;
  logic       serial_out, load_out, active_out, idle_out;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  exp_t  exp_q[$];

  always #5 clk_32f = ~clk_32f;

  phy_tx_serial #(.BC_SYMBOL(8'hBC), .SYNC_FRAMES(1)) dut (
    .clk_32f    (clk_32f),
    .rst        (rst),
    .data_in_0  (data_in_0),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .data_in_3  (data_in_3),
    .valid_in_0 (valid_in_0),
    .valid_in_1 (valid_in_1),
    .valid_in_2 (valid_in_2),
    .valid_in_3 (valid_in_3),
    .serial_out (serial_out),
    .load_out   (load_out),
    .active_out (active_out),
    .idle_out   (idle_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: a frame starts the cycle after load_out and lasts 32 bits
  int          rx_cnt = 0;
  logic [31:0] rx_sh  = '0;
  exp_t        cur;

  always @(negedge clk_32f) begin
    if (rx_cnt != 0) begin
      if (rx_cnt == 32) begin
        if (!mon_en) begin
          rx_cnt = 0;
        end else if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_pop: actual no queued frame, required one at %0t", $time);
          rx_cnt = 0;
        end else begin
          cur = exp_q.pop_front();
          check("idle_out", {31'd0, idle_out}, {31'd0, cur.idle});
        end
      end
      if (rx_cnt != 0) begin
        rx_sh  = {rx_sh[30:0], serial_out};
        rx_cnt = rx_cnt - 1;
        if (rx_cnt == 0) check("frame_bits", rx_sh, cur.bits);
      end
    end
    if (load_out === 1'b1) rx_cnt = 32;
  end

  // Reset for pre_cycles edges, then check the zero cycle and the BC preamble.
  // Returns at the negedge of the first load cycle.
  task automatic reset_preamble(input int pre_cycles);
    logic [7:0]  bc_v;
    logic [31:0] got;
    int          loads;
    bc_v  = BC;
    got   = '0;
    loads = 0;
    rst   = 1'b1;
    repeat (pre_cycles) @(negedge clk_32f);
    check("rst_serial", {31'd0, serial_out}, 32'd0);
    check("rst_active", {31'd0, active_out}, 32'd0);
    check("rst_idle",   {31'd0, idle_out},   32'd1);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk_32f);
      got = {got[30:0], serial_out};
      if (load_out === 1'b1) loads++;
      if (i == 16) check("sync_idle", {31'd0, idle_out}, 32'd1);
    end
    check("preamble_bits", got, {4{bc_v}});
    check("preamble_loads", loads, 32'd1);
    check("load_at_bit32", {31'd0, load_out}, 32'd1);
    check("active_before", {31'd0, active_out}, 32'd0);
  endtask

  // Called at a load negedge; returns at the next load negedge
  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3,
                            input logic [3:0] v, input logic [31:0] exp_bits,
                            input logic exp_idle, input bit t5, input bit scr);
    exp_t e;
    int   n;
    bit   got;
    data_in_0  = d0;   data_in_1  = d1;   data_in_2  = d2;   data_in_3  = d3;
    valid_in_0 = v[0]; valid_in_1 = v[1]; valid_in_2 = v[2]; valid_in_3 = v[3];
    e.bits = exp_bits;
    e.idle = exp_idle;
    exp_q.push_back(e);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk_32f);
      n++;
      if (n == 1) check("active_out", {31'd0, active_out}, 32'd1);
      if (scr && n == 3) begin
        data_in_0  = ~data_in_0;  data_in_1  = ~data_in_1;
        data_in_2  = ~data_in_2;  data_in_3  = ~data_in_3;
        valid_in_0 = ~valid_in_0; valid_in_1 = ~valid_in_1;
        valid_in_2 = ~valid_in_2; valid_in_3 = ~valid_in_3;
      end
      if (t5 && n == 11) data_in_2 = 8'h13;
      if (load_out === 1'b1) got = 1'b1;
    end
    check("load_period", n, 32'd32);
  endtask

  initial begin
    rst = 1'b1;
    data_in_0 = '0; data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
    valid_in_0 = 1'b0; valid_in_1 = 1'b0; valid_in_2 = 1'b0; valid_in_3 = 1'b0;

    reset_preamble(3);
    mon_en = 1'b1;
    send_frame(8'hF2, 8'h15, 8'hDD, 8'h45, 4'b1111, 32'hF215DD45, 1'b0, 1'b0, 1'b1);
    send_frame(8'hF2, 8'h15, 8'hDD, 8'h45, 4'b1101, 32'hF2BCDD45, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 32'hBCBCBCBC, 1'b1, 1'b0, 1'b1);
    send_frame(8'hF2, 8'h15, 8'hDD, 8'h45, 4'b1111, 32'hF215DD45, 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, 8'h5A, 8'hBC, 8'h01, 4'b1110, 32'hBC5ABC01, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 8'hFF, 8'h77, 8'h88, 4'b0001, 32'h00BCBCBC, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of lane 2 (bit 3 of 8'hDD)
    mon_en = 1'b0;
    data_in_0 = 8'hF2; data_in_1 = 8'h15; data_in_2 = 8'hDD; data_in_3 = 8'h45;
    valid_in_0 = 1'b1; valid_in_1 = 1'b1; valid_in_2 = 1'b1; valid_in_3 = 1'b1;
    repeat (21) @(negedge clk_32f);
    check("t6_bit3", {31'd0, serial_out}, 32'd1);
    rst = 1'b1;
    @(negedge clk_32f);
    check("t6_serial", {31'd0, serial_out}, 32'd0);
    check("t6_active", {31'd0, active_out}, 32'd0);
    check("t6_idle",   {31'd0, idle_out},   32'd1);
    reset_preamble(2);
    mon_en = 1'b1;
    send_frame(8'hF2, 8'h15, 8'hDD, 8'h45, 4'b1111, 32'hF215DD45, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b0;
    repeat (3) @(negedge clk_32f);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
